// File: rtl/elevator_controller_nfloor_if.sv
// Request/status bundle between call-button logic, the elevator controller and the
// motor/door drivers.
interface elevator_controller_nfloor_if #(
  parameter int unsigned NUM_FLOORS = 8,
  parameter int unsigned FLOOR_W    = $clog2(NUM_FLOORS)
);
  logic [NUM_FLOORS-1:0] floor_request;
  logic                  door_hold;
  logic [FLOOR_W-1:0]    current_floor;
  logic                  move_up;
  logic                  move_down;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] pending;
  logic                  idle;

  modport master (
    output floor_request, door_hold,
    input  current_floor, move_up, move_down, door_open, pending, idle
  );

  modport slave (
    input  floor_request, door_hold,
    output current_floor, move_up, move_down, door_open, pending, idle
  );
endinterface

// File: rtl/elevator_controller_nfloor.sv
// N-floor SCAN elevator controller: latches calls, sweeps in one direction while calls lie
// ahead, models per-floor travel time and a holdable timed door. All outputs registered.
module elevator_controller_nfloor #(
  parameter int unsigned NUM_FLOORS    = 8,
  parameter int unsigned FLOOR_W       = $clog2(NUM_FLOORS),
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 6
) (
  input logic                         clk,
  input logic                         rst,
  elevator_controller_nfloor_if.slave bus
);

  localparam int unsigned MaxCyc = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);
  localparam logic [CntW-1:0] TravelLoad = CntW'(TRAVEL_CYCLES - 1);
  localparam logic [CntW-1:0] DoorLoad   = CntW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StMove, StDoor} state_e;

  state_e                state_q;
  logic                  dir_up_q;
  logic [CntW-1:0]       cnt_q;
  logic [FLOOR_W-1:0]    current_floor_q;
  logic                  move_up_q, move_down_q, door_open_q, idle_q;
  logic [NUM_FLOORS-1:0] pending_q;

  logic [NUM_FLOORS-1:0] eff, one_cur, one_nxt;
  logic [FLOOR_W-1:0]    nxt_floor;
  logic                  ahead_up, ahead_dn;

  always_comb begin
    eff       = pending_q | bus.floor_request;
    nxt_floor = dir_up_q ? current_floor_q + FLOOR_W'(1) : current_floor_q - FLOOR_W'(1);
    one_cur   = '0;
    one_cur[current_floor_q] = 1'b1;
    one_nxt   = '0;
    one_nxt[nxt_floor] = 1'b1;
    ahead_up  = 1'b0;
    ahead_dn  = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (eff[i] && (i > 32'(current_floor_q))) ahead_up = 1'b1;
      if (eff[i] && (i < 32'(current_floor_q))) ahead_dn = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      dir_up_q        <= 1'b1;
      cnt_q           <= '0;
      current_floor_q <= '0;
      move_up_q       <= 1'b0;
      move_down_q     <= 1'b0;
      door_open_q     <= 1'b0;
      idle_q          <= 1'b1;
      pending_q       <= '0;
    end else begin
      pending_q <= eff;
      case (state_q)
        StIdle: begin
          // A call for the floor we are parked at beats any travel decision.
          if (eff[current_floor_q]) begin
            state_q     <= StDoor;
            door_open_q <= 1'b1;
            idle_q      <= 1'b0;
            cnt_q       <= DoorLoad;
            pending_q   <= eff & ~one_cur;
          end else if (ahead_up && (dir_up_q || !ahead_dn)) begin
            state_q   <= StMove;
            dir_up_q  <= 1'b1;
            move_up_q <= 1'b1;
            idle_q    <= 1'b0;
            cnt_q     <= TravelLoad;
          end else if (ahead_dn) begin
            state_q     <= StMove;
            dir_up_q    <= 1'b0;
            move_down_q <= 1'b1;
            idle_q      <= 1'b0;
            cnt_q       <= TravelLoad;
          end
        end
        StMove: begin
          if (cnt_q == '0) begin
            current_floor_q <= nxt_floor;
            if (eff[nxt_floor]) begin
              state_q     <= StDoor;
              move_up_q   <= 1'b0;
              move_down_q <= 1'b0;
              door_open_q <= 1'b1;
              cnt_q       <= DoorLoad;
              pending_q   <= eff & ~one_nxt;
            end else begin
              cnt_q <= TravelLoad;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StDoor: begin
          pending_q <= eff & ~one_cur;
          if (bus.door_hold || bus.floor_request[current_floor_q]) begin
            cnt_q <= DoorLoad;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else begin
            door_open_q <= 1'b0;
            if (dir_up_q ? ahead_up : ahead_dn) begin
              state_q     <= StMove;
              move_up_q   <= dir_up_q;
              move_down_q <= !dir_up_q;
              cnt_q       <= TravelLoad;
            end else if (dir_up_q ? ahead_dn : ahead_up) begin
              // Sweep exhausted: reverse only here or from idle.
              state_q     <= StMove;
              dir_up_q    <= !dir_up_q;
              move_up_q   <= !dir_up_q;
              move_down_q <= dir_up_q;
              cnt_q       <= TravelLoad;
            end else begin
              state_q <= StIdle;
              idle_q  <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.current_floor = current_floor_q;
  assign bus.move_up       = move_up_q;
  assign bus.move_down     = move_down_q;
  assign bus.door_open     = door_open_q;
  assign bus.pending       = pending_q;
  assign bus.idle          = idle_q;

endmodule

// File: tb/tb_elevator_controller_nfloor.sv
// Bench for elevator_controller_nfloor: directed scenarios plus random calls, scored each
// cycle against a timer/request-set model of the elevator.
module tb_elevator_controller_nfloor;
  localparam int TRAVEL = 4;
  localparam int DOOR   = 3;
  localparam int MIdle  = 0;
  localparam int MMove  = 1;
  localparam int MDoor  = 2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  elevator_controller_nfloor_if #(.NUM_FLOORS(8)) bus ();

  elevator_controller_nfloor #(
    .NUM_FLOORS   (8),
    .TRAVEL_CYCLES(TRAVEL),
    .DOOR_CYCLES  (DOOR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: mode, floor, sweep direction, cycles left in current phase, waiting calls.
  int         m_mode;
  int         m_floor;
  bit         m_up;
  int         m_left;
  logic [7:0] m_pend;
  int         stops[$];

  task automatic model_reset();
    m_mode = MIdle; m_floor = 0; m_up = 1'b1; m_left = 0; m_pend = 8'h00;
  endtask

  task automatic model_step(input logic [7:0] fr, input logic hold);
    logic [7:0] want, here;
    bit above, below;
    want  = m_pend | fr;
    here  = 8'd1 << m_floor;
    above = (want >> (m_floor + 1)) != 8'd0;
    below = (want & (here - 8'd1)) != 8'd0;
    m_pend = want;
    case (m_mode)
      MIdle: begin
        if ((want & here) != 8'd0) begin
          m_mode = MDoor; m_left = DOOR; m_pend = want & ~here;
        end else if (above && (m_up || !below)) begin
          m_mode = MMove; m_up = 1'b1; m_left = TRAVEL;
        end else if (below) begin
          m_mode = MMove; m_up = 1'b0; m_left = TRAVEL;
        end
      end
      MMove: begin
        m_left--;
        if (m_left == 0) begin
          m_floor = m_up ? m_floor + 1 : m_floor - 1;
          here = 8'd1 << m_floor;
          if ((want & here) != 8'd0) begin
            m_mode = MDoor; m_left = DOOR; m_pend = want & ~here;
          end else begin
            m_left = TRAVEL;
          end
        end
      end
      default: begin
        m_pend = want & ~here;
        if (hold || ((fr & here) != 8'd0)) begin
          m_left = DOOR;
        end else begin
          m_left--;
          if (m_left == 0) begin
            if (m_up ? above : below) begin
              m_mode = MMove; m_left = TRAVEL;
            end else if (m_up ? below : above) begin
              m_up = !m_up; m_mode = MMove; m_left = TRAVEL;
            end else begin
              m_mode = MIdle;
            end
          end
        end
      end
    endcase
  endtask

  // One clock: drive inputs, advance model, score outputs and invariants, log door stops.
  task automatic tick(input logic [7:0] fr, input logic hold);
    logic        prev_door;
    logic [14:0] exp_v, act_v;
    bus.floor_request = fr;
    bus.door_hold     = hold;
    prev_door         = bus.door_open;
    @(posedge clk);
    model_step(fr, hold);
    #1;
    exp_v = {3'(m_floor), (m_mode == MMove) && m_up, (m_mode == MMove) && !m_up,
             m_mode == MDoor, m_pend, m_mode == MIdle};
    act_v = {bus.current_floor, bus.move_up, bus.move_down, bus.door_open, bus.pending, bus.idle};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL model_step t=%0t actual={flr,up,dn,door,pend,idle}=%h required=%h",
               $time, act_v, exp_v);
    end
    checks++;
    if ((bus.move_up && bus.move_down) || (bus.door_open && (bus.move_up || bus.move_down))) begin
      failures++;
      $display("FAIL invariant t=%0t actual up=%b dn=%b door=%b required no overlap",
               $time, bus.move_up, bus.move_down, bus.door_open);
    end
    if (!prev_door && bus.door_open) stops.push_back(int'(bus.current_floor));
    bus.floor_request = 8'h00;
    bus.door_hold     = 1'b0;
  endtask

  task automatic run_until_idle(input int budget);
    int k;
    k = 0;
    while (!(m_mode == MIdle && bus.idle) && k < budget) begin
      tick(8'h00, 1'b0);
      k++;
    end
    checks++;
    if (k >= budget) begin
      failures++;
      $display("FAIL idle_timeout actual=%0d cycles required<%0d", k, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.floor_request = 8'h00;
    bus.door_hold     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.current_floor, bus.move_up, bus.move_down, bus.door_open, bus.pending, bus.idle}
        !== 15'h0001) begin
      failures++;
      $display("FAIL reset_state actual=%h required=0001",
               {bus.current_floor, bus.move_up, bus.move_down, bus.door_open, bus.pending,
                bus.idle});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_same_floor();
    int n;
    tick(8'h01, 1'b0);
    checks++;
    if (bus.door_open !== 1'b1 || bus.pending !== 8'h00) begin
      failures++;
      $display("FAIL same_floor_open actual door=%b pend=%h required door=1 pend=00",
               bus.door_open, bus.pending);
    end
    n = 0;
    for (int k = 0; k < 20 && bus.door_open; k++) begin
      n++;
      tick(8'h00, 1'b0);
    end
    checks++;
    if (n !== DOOR || bus.idle !== 1'b1) begin
      failures++;
      $display("FAIL same_floor_door_len actual=%0d idle=%b required=%0d idle=1", n, bus.idle, DOOR);
    end
  endtask

  task automatic test_single_trip();
    int n;
    int floors[$];
    logic [2:0] last;
    tick(8'h08, 1'b0);
    n = 0;
    last = bus.current_floor;
    for (int k = 0; k < 40 && bus.move_up; k++) begin
      n++;
      tick(8'h00, 1'b0);
      if (bus.current_floor != last) begin
        floors.push_back(int'(bus.current_floor));
        last = bus.current_floor;
      end
    end
    checks++;
    if (n !== 3 * TRAVEL) begin
      failures++;
      $display("FAIL trip_move_len actual=%0d required=%0d", n, 3 * TRAVEL);
    end
    checks++;
    if (floors.size() != 3 || floors[0] != 1 || floors[1] != 2 || floors[2] != 3) begin
      failures++;
      $display("FAIL trip_floors actual=%p required='{1,2,3}", floors);
    end
    checks++;
    if (bus.door_open !== 1'b1 || bus.current_floor !== 3'd3 || bus.pending[3] !== 1'b0) begin
      failures++;
      $display("FAIL trip_arrive actual door=%b flr=%0d pend=%h required door=1 flr=3 pend[3]=0",
               bus.door_open, bus.current_floor, bus.pending);
    end
    run_until_idle(100);
  endtask

  task automatic test_scan();
    tick(8'h04, 1'b0);
    run_until_idle(100);
    stops.delete();
    tick(8'h40, 1'b0);
    tick(8'h00, 1'b0);
    tick(8'h12, 1'b0);
    run_until_idle(200);
    checks++;
    if (stops.size() != 3 || stops[0] != 4 || stops[1] != 6 || stops[2] != 1) begin
      failures++;
      $display("FAIL scan_order actual=%p required='{4,6,1}", stops);
    end
  endtask

  task automatic test_door_hold();
    int n;
    tick(8'h20, 1'b0);
    run_until_idle(100);
    tick(8'h20, 1'b0);
    n = bus.door_open ? 1 : 0;
    for (int k = 0; k < 10; k++) begin
      tick(8'h00, 1'b1);
      if (bus.door_open) n++;
    end
    for (int k = 0; k < 20 && bus.door_open; k++) begin
      tick(8'h00, 1'b0);
      if (bus.door_open) n++;
    end
    checks++;
    if (n !== 10 + DOOR || bus.current_floor !== 3'd5) begin
      failures++;
      $display("FAIL door_hold_len actual=%0d flr=%0d required=%0d flr=5",
               n, bus.current_floor, 10 + DOOR);
    end
    run_until_idle(50);
  endtask

  task automatic test_reset_mid_move();
    tick(8'h08, 1'b0);
    run_until_idle(100);
    tick(8'h90, 1'b0);
    tick(8'h00, 1'b0);
    checks++;
    if (bus.pending !== 8'h90 || bus.move_up !== 1'b1 || bus.current_floor !== 3'd3) begin
      failures++;
      $display("FAIL premid_move actual pend=%h up=%b flr=%0d required pend=90 up=1 flr=3",
               bus.pending, bus.move_up, bus.current_floor);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.current_floor, bus.move_up, bus.move_down, bus.door_open, bus.pending, bus.idle}
        !== 15'h0001) begin
      failures++;
      $display("FAIL async_reset actual=%h required=0001",
               {bus.current_floor, bus.move_up, bus.move_down, bus.door_open, bus.pending,
                bus.idle});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_far_requests();
    tick(8'h10, 1'b0);
    run_until_idle(100);
    stops.delete();
    tick(8'h81, 1'b0);
    run_until_idle(200);
    checks++;
    if (stops.size() != 2 || stops[0] != 7 || stops[1] != 0) begin
      failures++;
      $display("FAIL far_order actual=%p required='{7,0}", stops);
    end
  endtask

  task automatic test_random();
    logic [7:0] fr;
    for (int k = 0; k < 800; k++) begin
      fr = ($urandom_range(0, 5) == 0) ? (8'd1 << $urandom_range(0, 7)) : 8'h00;
      tick(fr, $urandom_range(0, 15) == 0);
    end
    run_until_idle(800);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_reset();
    test_reset();
    test_same_floor();
    test_single_trip();
    test_scan();
    test_door_hold();
    test_reset_mid_move();
    test_far_requests();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
